// File: rtl/tile_hit_resolver.sv
// tile_hit_resolver: converts a ball contact pixel into a tile address using a
// sequential subtract divider, classifies the tile read back from the map and
// clears gift tiles. One classified result strobe per accepted request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for hit_req; captures coordinates relative to map
// S_CHECK | rejects coordinates outside the map area
// S_DIV   | subtracts tile sizes until both remainders are in range
// S_READ  | presents col/row to the map and classifies Tile_Type
// S_WRITE | one-cycle write of a cleared tile (gift collected)
// S_DONE  | one-cycle result strobe, then back to idle
module tile_hit_resolver #(
  parameter int TILE_W = 80,
  parameter int TILE_H = 80,
  parameter int COLS   = 8,
  parameter int ROWS   = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               hit_req,
  input  logic signed [10:0] pixelX,
  input  logic signed [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               EndGame,
  input  logic [1:0]         Tile_Type,
  output logic [2:0]         Xnum,
  output logic [2:0]         Ynum,
  output logic               writeEn,
  output logic [1:0]         information,
  output logic               busy,
  output logic               done,
  output logic [2:0]         result,
  output logic               gift_collected
);

  localparam logic signed [11:0] TW       = 12'(TILE_W);
  localparam logic signed [11:0] TH       = 12'(TILE_H);
  localparam logic signed [11:0] MAX_X    = 12'(COLS * TILE_W);
  localparam logic signed [11:0] MAX_Y    = 12'(ROWS * TILE_H);
  localparam logic [2:0]         COL_LAST = 3'(COLS - 1);
  localparam logic [2:0]         ROW_LAST = 3'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state;
  logic signed [11:0] rem_x;
  logic signed [11:0] rem_y;
  logic [2:0]         col;
  logic [2:0]         row;
  logic               write_q;
  logic               done_q;
  logic               gift_q;

  // EndGame suppresses strobes in the very cycle it is raised, not only the next one.
  assign writeEn        = write_q & ~EndGame;
  assign done           = done_q & ~EndGame;
  assign gift_collected = gift_q & ~EndGame;
  assign information    = 2'b00;

  // Request sequencing: capture, range check, divide, read, optional clear, report.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state   <= S_IDLE;
      rem_x   <= '0;
      rem_y   <= '0;
      col     <= '0;
      row     <= '0;
      Xnum    <= '0;
      Ynum    <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      gift_q  <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
    end else if (EndGame) begin
      state   <= S_IDLE;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      gift_q  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      gift_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hit_req) begin
            rem_x <= {pixelX[10], pixelX} - {topLeftX[10], topLeftX};
            rem_y <= {pixelY[10], pixelY} - {topLeftY[10], topLeftY};
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rem_x[11] || rem_y[11] || (rem_x >= MAX_X) || (rem_y >= MAX_Y)) begin
            result <= 3'b100;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (rem_x >= TW) begin
            rem_x <= rem_x - TW;
            if (col != COL_LAST) col <= col + 3'd1;
          end
          if (rem_y >= TH) begin
            rem_y <= rem_y - TH;
            if (row != ROW_LAST) row <= row + 3'd1;
          end
          // Quotients are final once neither remainder can be reduced.
          if ((rem_x < TW) && (rem_y < TH)) begin
            Xnum  <= col;
            Ynum  <= row;
            state <= S_READ;
          end
        end
        S_READ: begin
          unique case (Tile_Type)
            2'b00: begin
              result <= 3'b000;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
            2'b01: begin
              result <= 3'b001;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
            2'b11: begin
              result <= 3'b011;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
            default: begin
              result  <= 3'b010;
              write_q <= 1'b1;
              state   <= S_WRITE;
            end
          endcase
        end
        S_WRITE: begin
          done_q <= 1'b1;
          gift_q <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_hit_resolver.sv
// Bench for tile_hit_resolver: directed scenarios followed by randomized
// requests, each predicted from tile geometry with plain integer arithmetic
// against a bench-owned tile map.
module tb_tile_hit_resolver;

  localparam int TILE_W = 80;
  localparam int TILE_H = 80;
  localparam int COLS   = 8;
  localparam int ROWS   = 6;

  logic               clk = 1'b0;
  logic               resetN;
  logic               hit_req;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               EndGame;
  logic [1:0]         Tile_Type;
  logic [2:0]         Xnum;
  logic [2:0]         Ynum;
  logic               writeEn;
  logic [1:0]         information;
  logic               busy;
  logic               done;
  logic [2:0]         result;
  logic               gift_collected;

  logic [1:0] mem     [0:7][0:7];
  int         exp_map [0:7][0:7];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  int       t_req;
  int       e_res;
  int       e_lat;
  int       e_col;
  int       e_row;
  bit       e_oom;
  logic [2:0] x0;
  logic [2:0] y0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign Tile_Type = mem[Ynum][Xnum];

  tile_hit_resolver #(
    .TILE_W(TILE_W), .TILE_H(TILE_H), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .resetN(resetN), .hit_req(hit_req),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .EndGame(EndGame), .Tile_Type(Tile_Type), .Xnum(Xnum), .Ynum(Ynum),
    .writeEn(writeEn), .information(information), .busy(busy), .done(done),
    .result(result), .gift_collected(gift_collected)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Map store behaviour: a write strobe seen at a rising edge updates the tile.
  task automatic edge_upd();
    @(posedge clk);
    if (writeEn === 1'b1) mem[Ynum][Xnum] = information;
  endtask

  task automatic tick();
    edge_upd();
    @(negedge clk);
  endtask

  function automatic void predict(input int px, input int py, input int tx, input int ty);
    int rx;
    int ry;
    int m;
    int tt;
    rx = px - tx;
    ry = py - ty;
    e_oom = (rx < 0) || (ry < 0) || (rx >= COLS * TILE_W) || (ry >= ROWS * TILE_H);
    if (e_oom) begin
      e_res = 4;
      e_lat = 2;
      e_col = 0;
      e_row = 0;
    end else begin
      e_col = rx / TILE_W;
      e_row = ry / TILE_H;
      m = (e_col > e_row) ? e_col : e_row;
      tt = exp_map[e_row][e_col];
      case (tt)
        0:       e_res = 0;
        1:       e_res = 1;
        3:       e_res = 3;
        default: e_res = 2;
      endcase
      e_lat = 4 + m + ((e_res == 2) ? 1 : 0);
    end
  endfunction

  task automatic issue(input int px, input int py, input int tx, input int ty);
    pixelX   = 11'(px);
    pixelY   = 11'(py);
    topLeftX = 11'(tx);
    topLeftY = 11'(ty);
    predict(px, py, tx, ty);
    x0 = Xnum;
    y0 = Ynum;
    t_req = cyc;
    hit_req = 1'b1;
    tick();
    hit_req = 1'b0;
  endtask

  task automatic await_op(input int stray_at, input bit hit_on_done, input bit watch_idle);
    int wcnt;
    int wcyc;
    bit got;
    wcnt = 0;
    wcyc = -1;
    got = 1'b0;
    chk("busy_after_accept", busy, 1);
    for (int k = 0; k < 40; k++) begin
      if (writeEn === 1'b1) begin
        wcnt++;
        wcyc = cyc;
        chk("wr_information", information, 0);
        chk("wr_xnum", Xnum, e_col);
        chk("wr_ynum", Ynum, e_row);
      end
      hit_req = (stray_at > 0) && (cyc - t_req == stray_at);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("latency", cyc - t_req, e_lat);
      chk("result", result, e_res);
      chk("gift_pulse", gift_collected, (e_res == 2) ? 1 : 0);
      chk("write_count", wcnt, (e_res == 2) ? 1 : 0);
      if (e_res == 2) chk("write_cycle", wcyc, cyc - 1);
      if (e_oom) begin
        chk("oom_xnum_hold", Xnum, x0);
        chk("oom_ynum_hold", Ynum, y0);
      end else begin
        chk("xnum", Xnum, e_col);
        chk("ynum", Ynum, e_row);
      end
    end
    if (!e_oom && e_res == 2) exp_map[e_row][e_col] = 0;
    hit_req = hit_on_done;
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_single", done, 0);
    if (!e_oom) chk("map_entry", mem[e_row][e_col], exp_map[e_row][e_col]);
    if (watch_idle) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        mem[i][j] = 2'($urandom_range(3, 0));
        exp_map[i][j] = int'(mem[i][j]);
      end
    end
    resetN   = 1'b1;
    hit_req  = 1'b1;
    EndGame  = 1'b0;
    pixelX   = 11'sd100;
    pixelY   = 11'sd420;
    topLeftX = 11'sd0;
    topLeftY = 11'sd0;

    // Reset held with a pending request.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_write", writeEn, 0);
      chk("rst_xnum", Xnum, 0);
      chk("rst_ynum", Ynum, 0);
      chk("rst_result", result, 0);
      chk("rst_gift", gift_collected, 0);
      chk("rst_info", information, 0);
    end
    resetN  = 1'b0;
    hit_req = 1'b0;
    tick();
    chk("release_idle", busy, 0);

    // Request coinciding with EndGame is dropped.
    hit_req = 1'b1;
    EndGame = 1'b1;
    tick();
    hit_req = 1'b0;
    EndGame = 1'b0;
    chk("endgame_drop", busy, 0);
    tick();
    chk("endgame_drop2", busy, 0);

    // Solid tile.
    mem[5][1] = 2'b01;
    exp_map[5][1] = 1;
    issue(100, 420, 0, 0);
    await_op(0, 1'b0, 1'b0);

    // Gift, then the same tile again reads as empty.
    mem[4][5] = 2'b10;
    exp_map[4][5] = 2;
    issue(479, 399, 0, 0);
    await_op(0, 1'b0, 1'b0);
    issue(479, 399, 0, 0);
    await_op(0, 1'b0, 1'b0);

    // Out of map on both sides.
    issue(30, 10, 40, 0);
    await_op(0, 1'b0, 1'b0);
    issue(680, 10, 40, 0);
    await_op(0, 1'b0, 1'b0);

    // Abort as the write cycle begins.
    mem[4][5] = 2'b10;
    exp_map[4][5] = 2;
    issue(479, 399, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("abort_pre_write", writeEn, 0);
    edge_upd();
    #1 EndGame = 1'b1;
    @(negedge clk);
    chk("abort_write_gated", writeEn, 0);
    chk("abort_done_gated", done, 0);
    edge_upd();
    #1 EndGame = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_quiet", done, 0);
    end
    chk("abort_map", mem[4][5], 2);

    // Stray request while busy is neither served nor queued.
    issue(100, 420, 0, 0);
    await_op(3, 1'b0, 1'b1);

    // Request in the done cycle ignored, one cycle later accepted.
    issue(100, 420, 0, 0);
    await_op(0, 1'b1, 1'b0);
    issue(200, 100, 0, 0);
    await_op(0, 1'b0, 1'b1);

    // Randomized requests against the geometric model.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(5, 0));
      c = int'($urandom_range(7, 0));
      mem[r][c] = 2'($urandom_range(3, 0));
      exp_map[r][c] = int'(mem[r][c]);
      issue(int'($urandom_range(900, 0)) - 100, int'($urandom_range(700, 0)) - 100,
            int'($urandom_range(200, 0)) - 50, int'($urandom_range(200, 0)) - 50);
      await_op(0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_hit_resolver.md
Name: tile_hit_resolver

Overview:
Client-side master of the 6x8 tile map store. It turns a ball-contact pixel coordinate into a tile index with a sequential subtract-divider, reads the tile type over the map's combinational read port, and writes the tile back when a gift is collected. It reports a one-cycle classified result to the game controller, which uses it for bounce, score and level-exit decisions.

Parameters:
TILE_W, 80, tile width in pixels
TILE_H, 80, tile height in pixels
COLS, 8, map columns (Xnum range 0..COLS-1)
ROWS, 6, map rows (Ynum range 0..ROWS-1)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous reset, active-high despite the suffix (asserted = 1, sampled on posedge clk)
hit_req  in  1  single-cycle request strobe; sampled only when busy=0
pixelX  in  11 signed  contact X coordinate
pixelY  in  11 signed  contact Y coordinate
topLeftX  in  11 signed  map origin X
topLeftY  in  11 signed  map origin Y
EndGame  in  1  level restart; aborts any operation
Tile_Type  in  2  tile type read back for the current Xnum/Ynum (combinational in the map)
Xnum  out  3  tile column address to the map
Ynum  out  3  tile row address to the map
writeEn  out  1  one-cycle write strobe to the map
information  out  2  write data; always 2'b00 (cleared tile)
busy  out  1  high from the cycle after an accepted request until the cycle after done
done  out  1  one-cycle result strobe
result  out  3  000 empty, 001 solid, 010 gift collected, 011 exit tile, 100 out of map; valid only while done=1
gift_collected  out  1  one-cycle pulse, coincident with done when result=010

Behaviour:
- Reset (resetN=1): state IDLE; Xnum=Ynum=0, writeEn=0, information=0, busy=0, done=0, result=0, gift_collected=0; internal remainders and counters are cleared. Reset overrides every other input.
- IDLE: if hit_req=1 and EndGame=0, capture relX=pixelX-topLeftX and relY=pixelY-topLeftY as 12-bit signed values, clear col and row, and go to CHECK. Otherwise stay in IDLE.
- CHECK (busy=1): if relX<0, relY<0, relX>=COLS*TILE_W or relY>=ROWS*TILE_H, set result=100 and go to DONE. Otherwise go to DIV.
- DIV: in each cycle, if remX>=TILE_W then remX-=TILE_W and col++; independently, if remY>=TILE_H then remY-=TILE_H and row++. The first cycle in which neither subtraction happens goes to READ, so DIV lasts max(col,row)+1 cycles.
- READ: Xnum=col and Ynum=row. Xnum/Ynum are registered and stable for the whole READ cycle; Tile_Type is latched at the end of READ.
  - 00 gives result 000.
  - 01 gives result 001.
  - 11 gives result 011.
  - For these three, go to DONE.
  - 10 gives result 010 and goes to WRITE.
- WRITE: writeEn=1 and information=00 for exactly one cycle, with Xnum/Ynum unchanged. Then go to DONE.
- DONE: done=1 and result valid for one cycle; gift_collected=1 if result=010. Next state is IDLE and busy drops in the following cycle.
- Latency: with the request in cycle T, done is asserted in cycle T+4+max(col,row), plus 1 cycle for a gift. An out-of-map request has done in cycle T+2.
- hit_req while busy=1 is ignored and not queued. hit_req in the same cycle as done is also ignored; the earliest new accept is the IDLE cycle after DONE.
- EndGame=1 in any state returns to IDLE in the next cycle. No done or gift_collected is issued, writeEn is forced to 0 in that same cycle, and busy=0 next cycle. A hit_req coinciding with EndGame is dropped.
- Xnum/Ynum hold their last value in IDLE. Only DIV can change col/row, and they saturate at COLS-1/ROWS-1 (unreachable after CHECK, but required).
- information is constant 00. writeEn is never high outside WRITE.

Test Plan:
- Reset: hold resetN=1 for 2 cycles with hit_req=1 -> all outputs 0, busy=0. Release, then pulse hit_req -> accepted only after release.
- Solid tile: origin (0,0), pixel (100,420), map[5][1]=01, request at T -> busy from T+1, Xnum=1/Ynum=5 in cycle T+8, done=1 with result=001 in cycle T+9, writeEn never asserted.
- Gift: origin (0,0), pixel (479,399), map[4][5]=10 -> writeEn=1 with Xnum=5, Ynum=4, information=00 in cycle T+9; done=1, result=010 and gift_collected=1 in cycle T+10; a second identical request returns result=000.
- Out of map: origin (40,0), pixel (30,10) -> done in cycle T+2 with result=100 and no map access. Repeat with pixel (680,10) -> result=100.
- Abort: start the gift request, assert EndGame in the WRITE-entry cycle -> writeEn=0, no done, busy=0 the next cycle, and the map entry is unchanged.
- Busy rejection: pulse hit_req at T+3 during an active request -> exactly one done. A hit_req in the done cycle is ignored; a hit_req one cycle later is accepted.
